// File: rtl/keypad_field_sequencer_pkg.sv
// rtl/keypad_field_sequencer_pkg.sv - shared types, defaults and helpers for the keypad field sequencer
package keypad_field_sequencer_pkg;

    localparam int DEF_N_FIELDS = 7;
    localparam int DEF_DIGITS   = 4;
    localparam int DEF_VAL_W    = 14;
    localparam int DEF_IDX_W    = 3;

    typedef enum logic [1:0] {
        ST_ENTRY     = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_SHOW      = 2'd3
    } state_t;

    // Higher encoding wins when several keys rise in the same cycle.
    typedef enum logic [2:0] {
        EV_NONE  = 3'd0,
        EV_DIGIT = 3'd1,
        EV_BKSP  = 3'd2,
        EV_NEXT  = 3'd3,
        EV_CLEAR = 3'd4
    } key_event_t;

    function automatic int min_val_w(input int digits);
        int max_val;
        max_val = 1;
        for (int i = 0; i < digits; i++) begin
            max_val = max_val * 10;
        end
        return $clog2(max_val);
    endfunction

endpackage

// File: rtl/keypad_field_sequencer_bcd_to_bin.sv
// rtl/keypad_field_sequencer_bcd_to_bin.sv - combinational packed-BCD to binary converter
module bcd_to_bin #(
    parameter int DIGITS = 4,
    parameter int VAL_W  = 14
) (
    input  logic [4*DIGITS-1:0] i_bcd,
    output logic [VAL_W-1:0]    o_bin
);

    // Horner evaluation from the most significant digit: acc = acc*10 + digit.
    always_comb begin
        o_bin = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            o_bin = (o_bin << 3) + (o_bin << 1) + VAL_W'(i_bcd[4*i +: 4]);
        end
    end

endmodule

// File: rtl/keypad_field_sequencer.sv
// rtl/keypad_field_sequencer.sv - multi-field keypad entry with classifier START/DONE handshake
module keypad_field_sequencer
    import keypad_field_sequencer_pkg::*;
#(
    parameter int N_FIELDS = DEF_N_FIELDS,
    parameter int DIGITS   = DEF_DIGITS,
    parameter int VAL_W    = DEF_VAL_W,
    parameter int IDX_W    = DEF_IDX_W
) (
    input  logic                      CLOCK_50,
    input  logic                      RESET_N,
    input  logic [9:0]                KEY_DIGIT,
    input  logic                      KEY_NEXT,
    input  logic                      KEY_BKSP,
    input  logic                      KEY_CLEAR,
    input  logic                      DONE,
    input  logic                      RESULT_IN,
    output logic                      START,
    output logic [N_FIELDS*VAL_W-1:0] FIELDS,
    output logic [IDX_W-1:0]          FIELD_IDX,
    output logic [4*DIGITS-1:0]       CUR_BCD,
    output logic [2:0]                CUR_NDIG,
    output logic                      RESULT,
    output logic                      RESULT_VALID,
    output logic                      BUSY
);

    localparam int                BCD_W    = 4 * DIGITS;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_FIELDS - 1);
    localparam logic [2:0]        NDIG_MAX = 3'(DIGITS);

    state_t                    r_state;
    logic [9:0]                r_digit_q;
    logic                      r_next_q;
    logic                      r_bksp_q;
    logic                      r_clear_q;
    logic                      r_start;
    logic [N_FIELDS*VAL_W-1:0] r_fields;
    logic [IDX_W-1:0]          r_field_idx;
    logic [BCD_W-1:0]          r_cur_bcd;
    logic [2:0]                r_cur_ndig;
    logic                      r_result;
    logic                      r_result_valid;

    logic [9:0]                w_dig_rise;
    logic                      w_dig_one;
    logic [3:0]                w_dig_val;
    key_event_t                w_event;
    logic [VAL_W-1:0]          w_bin;

    assign w_dig_rise = KEY_DIGIT & ~r_digit_q;
    assign w_dig_one  = $onehot(w_dig_rise);

    always_comb begin
        w_dig_val = '0;
        for (int i = 0; i < 10; i++) begin
            if (w_dig_rise[i]) begin
                w_dig_val = 4'(i);
            end
        end
    end

    always_comb begin
        w_event = EV_NONE;
        if (KEY_CLEAR && !r_clear_q) begin
            w_event = EV_CLEAR;
        end else if (KEY_NEXT && !r_next_q) begin
            w_event = EV_NEXT;
        end else if (KEY_BKSP && !r_bksp_q) begin
            w_event = EV_BKSP;
        end else if (w_dig_one) begin
            w_event = EV_DIGIT;
        end
    end

    bcd_to_bin #(
        .DIGITS (DIGITS),
        .VAL_W  (VAL_W)
    ) u_bcd_to_bin (
        .i_bcd  (r_cur_bcd),
        .o_bin  (w_bin)
    );

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state        <= ST_ENTRY;
            r_digit_q      <= '0;
            r_next_q       <= 1'b0;
            r_bksp_q       <= 1'b0;
            r_clear_q      <= 1'b0;
            r_start        <= 1'b0;
            r_fields       <= '0;
            r_field_idx    <= '0;
            r_cur_bcd      <= '0;
            r_cur_ndig     <= '0;
            r_result       <= 1'b0;
            r_result_valid <= 1'b0;
        end else begin
            r_digit_q <= KEY_DIGIT;
            r_next_q  <= KEY_NEXT;
            r_bksp_q  <= KEY_BKSP;
            r_clear_q <= KEY_CLEAR;
            r_start   <= 1'b0;

            if (w_event == EV_CLEAR) begin
                r_state        <= ST_ENTRY;
                r_fields       <= '0;
                r_field_idx    <= '0;
                r_cur_bcd      <= '0;
                r_cur_ndig     <= '0;
                r_result_valid <= 1'b0;
            end else begin
                case (r_state)
                    ST_ENTRY: begin
                        case (w_event)
                            EV_DIGIT: begin
                                if (r_cur_ndig < NDIG_MAX) begin
                                    r_cur_bcd  <= (r_cur_bcd << 4) | BCD_W'(w_dig_val);
                                    r_cur_ndig <= r_cur_ndig + 3'd1;
                                end
                            end
                            EV_BKSP: begin
                                if (r_cur_ndig != 3'd0) begin
                                    r_cur_bcd  <= r_cur_bcd >> 4;
                                    r_cur_ndig <= r_cur_ndig - 3'd1;
                                end
                            end
                            EV_NEXT: begin
                                r_fields[r_field_idx*VAL_W +: VAL_W] <= w_bin;
                                r_cur_bcd  <= '0;
                                r_cur_ndig <= '0;
                                if (r_field_idx < LAST_IDX) begin
                                    r_field_idx <= r_field_idx + 1'b1;
                                end else begin
                                    r_state <= ST_LAUNCH;
                                    r_start <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                    // START is high for exactly the cycle spent here; DONE is not yet accepted.
                    ST_LAUNCH: begin
                        r_state <= ST_WAIT_DONE;
                    end
                    ST_WAIT_DONE: begin
                        if (DONE) begin
                            r_result       <= RESULT_IN;
                            r_result_valid <= 1'b1;
                            r_state        <= ST_SHOW;
                        end
                    end
                    ST_SHOW: begin
                        if (w_event == EV_NEXT) begin
                            r_fields       <= '0;
                            r_field_idx    <= '0;
                            r_result_valid <= 1'b0;
                            r_state        <= ST_ENTRY;
                        end
                    end
                    default: r_state <= ST_ENTRY;
                endcase
            end
        end
    end

    assign START        = r_start;
    assign FIELDS       = r_fields;
    assign FIELD_IDX    = r_field_idx;
    assign CUR_BCD      = r_cur_bcd;
    assign CUR_NDIG     = r_cur_ndig;
    assign RESULT       = r_result;
    assign RESULT_VALID = r_result_valid;
    assign BUSY         = (r_state == ST_LAUNCH) || (r_state == ST_WAIT_DONE);

endmodule

// File: tb/tb_keypad_field_sequencer.sv
// tb/tb_keypad_field_sequencer.sv - directed bench for keypad_field_sequencer (default and small builds)
module tb_keypad_field_sequencer;

    logic        clk;
    logic        rst_n;
    logic [9:0]  key_digit;
    logic        key_next, key_bksp, key_clear, done, result_in;
    logic        start, result, result_valid, busy;
    logic [97:0] fields;
    logic [2:0]  field_idx;
    logic [15:0] cur_bcd;
    logic [2:0]  cur_ndig;

    logic [9:0]  p_key_digit;
    logic        p_key_next;
    logic        p_start, p_result, p_result_valid, p_busy;
    logic [13:0] p_fields;
    logic [0:0]  p_field_idx;
    logic [7:0]  p_cur_bcd;
    logic [2:0]  p_cur_ndig;

    int n_cmp = 0;
    int n_bad = 0;
    logic [97:0] exp_fields;

    keypad_field_sequencer dut (
        .CLOCK_50(clk), .RESET_N(rst_n), .KEY_DIGIT(key_digit), .KEY_NEXT(key_next),
        .KEY_BKSP(key_bksp), .KEY_CLEAR(key_clear), .DONE(done), .RESULT_IN(result_in),
        .START(start), .FIELDS(fields), .FIELD_IDX(field_idx), .CUR_BCD(cur_bcd),
        .CUR_NDIG(cur_ndig), .RESULT(result), .RESULT_VALID(result_valid), .BUSY(busy)
    );

    keypad_field_sequencer #(.N_FIELDS(2), .DIGITS(2), .VAL_W(7), .IDX_W(1)) dut_p (
        .CLOCK_50(clk), .RESET_N(rst_n), .KEY_DIGIT(p_key_digit), .KEY_NEXT(p_key_next),
        .KEY_BKSP(1'b0), .KEY_CLEAR(1'b0), .DONE(1'b0), .RESULT_IN(1'b0),
        .START(p_start), .FIELDS(p_fields), .FIELD_IDX(p_field_idx), .CUR_BCD(p_cur_bcd),
        .CUR_NDIG(p_cur_ndig), .RESULT(p_result), .RESULT_VALID(p_result_valid), .BUSY(p_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_cmp++;
        if (obs !== expv) begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Keys change on the falling edge; exactly one rising edge sees them asserted.
    task automatic tap(input logic [9:0] d, input logic n, input logic b, input logic c);
        @(negedge clk);
        key_digit = d; key_next = n; key_bksp = b; key_clear = c;
        @(negedge clk);
        key_digit = '0; key_next = 1'b0; key_bksp = 1'b0; key_clear = 1'b0;
    endtask

    task automatic dig(input int v);
        logic [9:0] one;
        one = 10'd1;
        tap(one << v, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tap_p(input logic [9:0] d, input logic n);
        @(negedge clk);
        p_key_digit = d; p_key_next = n;
        @(negedge clk);
        p_key_digit = '0; p_key_next = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; key_digit = '0; key_next = 1'b0; key_bksp = 1'b0; key_clear = 1'b0;
        done = 1'b0; result_in = 1'b0; p_key_digit = '0; p_key_next = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_idx", field_idx, 3'd0);
        chk("rst_bcd", cur_bcd, 16'h0);
        chk("rst_ndig", cur_ndig, 3'd0);
        chk("rst_fields", fields, 98'd0);
        chk("rst_start", start, 1'b0);
        chk("rst_rv", result_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);

        tap('0, 1'b0, 1'b1, 1'b0);
        chk("bksp_empty_ndig", cur_ndig, 3'd0);

        dig(1); dig(2); dig(3); dig(4); dig(5);
        chk("limit_bcd", cur_bcd, 16'h1234);
        chk("limit_ndig", cur_ndig, 3'd4);
        tap('0, 1'b0, 1'b1, 1'b0);
        chk("bksp_bcd", cur_bcd, 16'h0123);
        chk("bksp_ndig", cur_ndig, 3'd3);
        tap('0, 1'b1, 1'b0, 1'b0);
        chk("commit_f0", fields[13:0], 14'd123);
        chk("commit_idx", field_idx, 3'd1);
        chk("commit_bcd", cur_bcd, 16'h0);

        dig(1); dig(2);
        chk("pre_rst_bcd", cur_bcd, 16'h0012);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_bcd", cur_bcd, 16'h0);
        chk("async_rst_ndig", cur_ndig, 3'd0);
        chk("async_rst_idx", field_idx, 3'd0);
        chk("async_rst_fields", fields, 98'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        dig(6); tap('0, 1'b1, 1'b0, 1'b0);
        dig(1); dig(4); dig(8); tap('0, 1'b1, 1'b0, 1'b0);
        dig(7); dig(2);
        tap(10'b0010000000, 1'b1, 1'b0, 1'b0);
        chk("simul_f2", fields[41:28], 14'd72);
        chk("simul_idx", field_idx, 3'd3);
        chk("simul_ndig", cur_ndig, 3'd0);
        tap(10'b0000000110, 1'b0, 1'b0, 1'b0);
        chk("multi_dig_ndig", cur_ndig, 3'd0);
        dig(3); dig(5); tap('0, 1'b1, 1'b0, 1'b0);
        tap('0, 1'b1, 1'b0, 1'b0);
        dig(3); dig(3); tap('0, 1'b1, 1'b0, 1'b0);
        dig(5); dig(0);
        chk("last_idx", field_idx, 3'd6);

        @(negedge clk);
        key_next = 1'b1;
        @(negedge clk);
        key_next = 1'b0;
        chk("launch_start", start, 1'b1);
        chk("launch_busy", busy, 1'b1);
        chk("launch_idx", field_idx, 3'd6);
        done = 1'b1; result_in = 1'b0;
        @(negedge clk);
        done = 1'b0;
        chk("start_one_cycle", start, 1'b0);
        chk("done_with_start_ignored", result_valid, 1'b0);
        chk("wait_busy", busy, 1'b1);
        exp_fields = {14'd50, 14'd33, 14'd0, 14'd35, 14'd72, 14'd148, 14'd6};
        chk("form_fields", fields, exp_fields);
        repeat (3) @(negedge clk);
        chk("wait_still_busy", busy, 1'b1);
        done = 1'b1; result_in = 1'b1;
        @(negedge clk);
        done = 1'b0; result_in = 1'b0;
        chk("show_result", result, 1'b1);
        chk("show_rv", result_valid, 1'b1);
        chk("show_busy", busy, 1'b0);

        tap('0, 1'b1, 1'b0, 1'b0);
        chk("newform_fields", fields, 98'd0);
        chk("newform_idx", field_idx, 3'd0);
        chk("newform_rv", result_valid, 1'b0);
        chk("newform_result_kept", result, 1'b1);

        dig(9);
        for (int i = 0; i < 7; i++) tap('0, 1'b1, 1'b0, 1'b0);
        chk("abort_pre_f0", fields[13:0], 14'd9);
        chk("abort_pre_busy", busy, 1'b1);
        tap('0, 1'b0, 1'b0, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_idx", field_idx, 3'd0);
        chk("abort_fields", fields, 98'd0);
        done = 1'b1; result_in = 1'b0;
        @(negedge clk);
        done = 1'b0;
        @(negedge clk);
        chk("abort_late_done_rv", result_valid, 1'b0);
        chk("abort_late_done_result", result, 1'b1);
        chk("abort_late_done_busy", busy, 1'b0);

        tap_p(10'b1000000000, 1'b0);
        tap_p(10'b1000000000, 1'b0);
        chk("p_bcd", p_cur_bcd, 8'h99);
        tap_p('0, 1'b1);
        chk("p_idx", p_field_idx, 1'b1);
        @(negedge clk);
        p_key_next = 1'b1;
        @(negedge clk);
        p_key_next = 1'b0;
        chk("p_start", p_start, 1'b1);
        chk("p_fields", p_fields, {7'd0, 7'd99});
        @(negedge clk);
        chk("p_start_drop", p_start, 1'b0);
        chk("p_busy", p_busy, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
